// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads one word from program memory at pc on a
// control-unit request and hands it to the instruction register with a
// one-cycle ir_load strobe. It owns the program counter, including the
// post-fetch increment and the jump load.
// Optional feature: define FETCH_TIMEOUT_EN to abandon a memory request that
// receives no ack within TIMEOUT_CYC cycles. The abandoned fetch is reported
// with a one-cycle fetch_err pulse.
module instr_fetch #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int RESET_PC    = 0,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_load,
  output logic              busy,
  output logic              fetch_done,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t state;

  // Reject configurations that cannot produce a working timeout.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT_CYC must be at least 1");
  end

  // The memory address is the program counter itself. It is stable during
  // REQ because pc changes only in IDLE and LOAD.
  assign mem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign fetch_err = 1'b0;
`endif

  // Fetch FSM together with all of its registered outputs and the program counter.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      pc         <= ADDR_W'(RESET_PC);
      ir_data    <= '0;
      mem_rd     <= 1'b0;
      ir_load    <= 1'b0;
      fetch_done <= 1'b0;
      busy       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt    <= '0;
      fetch_err  <= 1'b0;
`endif
    end else begin
      // Strobes are high for a single cycle only.
      ir_load    <= 1'b0;
      fetch_done <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Apply the jump first, so a fetch requested in the same cycle
          // reads from the new pc.
          if (pc_load) pc <= pc_load_val;
          if (fetch_req) begin
            state  <= REQ;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        REQ: begin
          // An ack takes priority over a timeout that expires on the same edge.
          if (mem_ack) begin
            ir_data    <= mem_data;
            mem_rd     <= 1'b0;
            ir_load    <= 1'b1;
            fetch_done <= 1'b1;
            state      <= LOAD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        LOAD: begin
          pc    <= pc + ADDR_W'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Expected behaviour comes from a
// transaction-level model: a model program memory, a model pc, and the
// per-fetch timing rules.
module tb_instr_fetch;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int RESET_PC = 0;
  localparam int NWORDS   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              clear_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic              pc_load = 1'b0;
  logic [ADDR_W-1:0] pc_load_val = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] ir_data;
  logic              ir_load;
  logic              busy;
  logic              fetch_done;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;

  instr_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC), .TIMEOUT_CYC(15)
  ) dut (
    .clk(clk), .clear_n(clear_n), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_data(mem_data), .ir_data(ir_data),
    .ir_load(ir_load), .busy(busy), .fetch_done(fetch_done), .pc(pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [DATA_W-1:0] memv [NWORDS];
  int                mpc;
  logic [DATA_W-1:0] mir;
  int                exp_loads = 0;
  int                seen_loads = 0;

  always @(negedge clk) if (ir_load === 1'b1) seen_loads++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One complete fetch. jump/jval drive pc_load together with fetch_req.
  // dly is the number of cycles before ack. noise injects pc_load and
  // fetch_req pulses during REQ. Those pulses must have no effect.
  task automatic do_fetch(input bit jump, input int jval, input int dly, input bit noise);
    int ea;
    logic [DATA_W-1:0] ev;
    @(negedge clk);
    // An ack that arrives while no read is pending must be ignored.
    mem_ack = 1'b1; mem_data = 8'hEE;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_no_load", ir_load, 0);
    chk("idle_ack_ir_kept", ir_data, mir);
    fetch_req = 1'b1; pc_load = jump; pc_load_val = ADDR_W'(jval);
    ea = jump ? (jval % NWORDS) : mpc;
    ev = memv[ea];
    @(negedge clk);
    fetch_req = 1'b0; pc_load = 1'b0;
    chk("req_busy", busy, 1);
    chk("req_mem_rd", mem_rd, 1);
    chk("req_addr", mem_addr, ea);
    for (int i = 0; i < dly; i++) begin
      if (noise) begin
        fetch_req = 1'b1; pc_load = 1'b1; pc_load_val = ADDR_W'($urandom);
      end
      @(negedge clk);
      fetch_req = 1'b0; pc_load = 1'b0;
      chk("wait_mem_rd", mem_rd, 1);
      chk("wait_addr", mem_addr, ea);
      chk("wait_no_load", ir_load, 0);
    end
    mem_ack = 1'b1; mem_data = ev;
    @(negedge clk);
    mem_ack = 1'b0; mem_data = DATA_W'($urandom);
    exp_loads++;
    mir = ev;
    chk("load_strobe", ir_load, 1);
    chk("load_done", fetch_done, 1);
    chk("load_ir", ir_data, ev);
    chk("load_rd_low", mem_rd, 0);
    chk("load_pc_old", pc, ea);
    @(negedge clk);
    mpc = (ea + 1) % NWORDS;
    chk("post_load_low", ir_load, 0);
    chk("post_done_low", fetch_done, 0);
    chk("post_busy", busy, 0);
    chk("post_pc", pc, mpc);
    chk("post_ir_held", ir_data, mir);
    chk("post_no_err", fetch_err, 0);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) memv[i] = DATA_W'($urandom);
    memv[0]  = 8'hA5;
    memv[1]  = 8'h3C;
    memv[15] = 8'h5A;
    mpc = RESET_PC;
    mir = '0;

    // Reset state
    #1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ir_load", ir_load, 0);
    chk("rst_ir_data", ir_data, 0);
    chk("rst_fetch_err", fetch_err, 0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;

    // Directed cases: 1-cycle ack at pc 0, delayed ack, jump to F with wrap
    do_fetch(0, 0, 0, 0);
    do_fetch(0, 0, 5, 0);
    do_fetch(1, 15, 0, 0);
    chk("wrap_pc", pc, 0);
    // Request and jump pulsed during REQ are ignored
    do_fetch(0, 0, 3, 1);

    // Randomized fetches
    for (int n = 0; n < 40; n++)
      do_fetch($urandom_range(0, 1), $urandom_range(0, NWORDS - 1),
               $urandom_range(0, 6), $urandom_range(0, 1));

    // Reset during REQ aborts the fetch at once
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("pre_abort_rd", mem_rd, 1);
    clear_n = 1'b0;
    #1;
    mpc = RESET_PC;
    mir = '0;
    chk("abort_rd", mem_rd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pc", pc, RESET_PC);
    chk("abort_ir", ir_data, 0);
    chk("abort_load", ir_load, 0);
    @(negedge clk);
    clear_n = 1'b1;
    mem_ack = 1'b1; mem_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      chk("after_abort_no_load", ir_load, 0);
      chk("after_abort_idle", busy, 0);
    end

`ifdef FETCH_TIMEOUT_EN
    // No ack: mem_rd stays high for 15 REQ cycles, then fetch_err pulses
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("tmo_wait_rd", mem_rd, 1);
      chk("tmo_wait_err", fetch_err, 0);
      @(negedge clk);
    end
    chk("tmo_err", fetch_err, 1);
    chk("tmo_rd_low", mem_rd, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_pc", pc, mpc);
    chk("tmo_no_load", ir_load, 0);
    chk("tmo_ir_kept", ir_data, mir);
    @(negedge clk);
    chk("tmo_err_pulse", fetch_err, 0);
`endif

    // Total strobe count: one per completed fetch, none for aborted ones
    @(negedge clk);
    chk("load_count", seen_loads, exp_loads);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
